// File: rtl/date_counter.sv
// Calendar stage of the century clock: BCD day/month/year with month lengths,
// leap years, validated date load and a one-cycle century carry on 31 Dec 99 rollover.
module date_counter #(
   parameter logic [7:0] START_DAY   = 8'h01,
   parameter logic [7:0] START_MONTH = 8'h01,
   parameter logic [7:0] START_YEAR  = 8'h00,
   parameter bit         YEAR00_LEAP = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       day_tick,
   input  logic       load_en,
   input  logic [7:0] load_day,
   input  logic [7:0] load_month,
   input  logic [7:0] load_year,
   output logic [3:0] day_1,
   output logic [1:0] day_10,
   output logic [3:0] month_1,
   output logic       month_10,
   output logic [3:0] year_1,
   output logic [3:0] year_10,
   output logic       leap,
   output logic       clock_century,
   output logic       load_err
);

   function automatic logic leap_of(input logic [3:0] y10, input logic [3:0] y1);
      if (y10 == 4'd0 && y1 == 4'd0) return YEAR00_LEAP;
      if (!y10[0]) return (y1 == 4'd0) || (y1 == 4'd4) || (y1 == 4'd8);
      return (y1 == 4'd2) || (y1 == 4'd6);
   endfunction

   function automatic logic [7:0] last_day(input logic [7:0] mon, input logic lp);
      case (mon)
         8'h02:                      return lp ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
         default:                    return 8'h31;
      endcase
   endfunction

   logic [1:0] day10_q, day10_d;
   logic [3:0] day1_q, day1_d;
   logic       mon10_q, mon10_d;
   logic [3:0] mon1_q, mon1_d;
   logic [3:0] yr10_q, yr10_d;
   logic [3:0] yr1_q, yr1_d;
   logic       century_q, century_d;
   logic       err_q, err_d;

   logic [7:0] day_cur, mon_cur, ld_last;
   logic       cur_leap, ld_leap, ld_ok;

   always_comb begin
      day_cur  = {2'b00, day10_q, day1_q};
      mon_cur  = {3'b000, mon10_q, mon1_q};
      cur_leap = leap_of(yr10_q, yr1_q);
      ld_leap  = leap_of(load_year[7:4], load_year[3:0]);
      ld_last  = last_day(load_month, ld_leap);
      // With every nibble known to be a decimal digit, BCD bytes compare numerically.
      ld_ok = (load_day[7:4] <= 4'd9) && (load_day[3:0] <= 4'd9) &&
              (load_month[7:4] <= 4'd9) && (load_month[3:0] <= 4'd9) &&
              (load_year[7:4] <= 4'd9) && (load_year[3:0] <= 4'd9) &&
              (load_month >= 8'h01) && (load_month <= 8'h12) &&
              (load_day >= 8'h01) && (load_day <= ld_last);

      day10_d   = day10_q;
      day1_d    = day1_q;
      mon10_d   = mon10_q;
      mon1_d    = mon1_q;
      yr10_d    = yr10_q;
      yr1_d     = yr1_q;
      century_d = 1'b0;
      err_d     = 1'b0;

      if (load_en) begin
         if (ld_ok) begin
            day10_d = load_day[5:4];
            day1_d  = load_day[3:0];
            mon10_d = load_month[4];
            mon1_d  = load_month[3:0];
            yr10_d  = load_year[7:4];
            yr1_d   = load_year[3:0];
         end else begin
            err_d = 1'b1;
         end
      end else if (day_tick) begin
         if (day_cur == last_day(mon_cur, cur_leap)) begin
            day10_d = 2'd0;
            day1_d  = 4'd1;
            if (mon_cur == 8'h12) begin
               mon10_d = 1'b0;
               mon1_d  = 4'd1;
               if (yr1_q == 4'd9) begin
                  yr1_d = 4'd0;
                  if (yr10_q == 4'd9) begin
                     yr10_d    = 4'd0;
                     century_d = 1'b1;
                  end else begin
                     yr10_d = yr10_q + 4'd1;
                  end
               end else begin
                  yr1_d = yr1_q + 4'd1;
               end
            end else if (mon1_q == 4'd9) begin
               mon10_d = 1'b1;
               mon1_d  = 4'd0;
            end else begin
               mon1_d = mon1_q + 4'd1;
            end
         end else if (day1_q == 4'd9) begin
            day1_d  = 4'd0;
            day10_d = day10_q + 2'd1;
         end else begin
            day1_d = day1_q + 4'd1;
         end
      end
   end

   // rst_n is active-high to match the sibling counters' port naming.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         day10_q   <= START_DAY[5:4];
         day1_q    <= START_DAY[3:0];
         mon10_q   <= START_MONTH[4];
         mon1_q    <= START_MONTH[3:0];
         yr10_q    <= START_YEAR[7:4];
         yr1_q     <= START_YEAR[3:0];
         century_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         day10_q   <= day10_d;
         day1_q    <= day1_d;
         mon10_q   <= mon10_d;
         mon1_q    <= mon1_d;
         yr10_q    <= yr10_d;
         yr1_q     <= yr1_d;
         century_q <= century_d;
         err_q     <= err_d;
      end
   end

   assign day_10        = day10_q;
   assign day_1         = day1_q;
   assign month_10      = mon10_q;
   assign month_1       = mon1_q;
   assign year_10       = yr10_q;
   assign year_1        = yr1_q;
   assign leap          = cur_leap;
   assign clock_century = century_q;
   assign load_err      = err_q;

endmodule
